// File: rtl/ram_sync_read_be_init.sv
// Single-port data RAM with a synchronous, registered read and per-byte write enables.
// A valid/ready request handshake sits in front of the array.
// After reset, or on request, a hardware sweep writes INIT_VALUE to every word.
module ram_sync_read_be_init #(
  parameter int unsigned             AWIDTH     = 3,
  parameter int unsigned             DWIDTH     = 32,
  parameter logic [DWIDTH-1:0]       INIT_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       init_start,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       we,
  input  logic [AWIDTH-1:0]          addr,
  input  logic [DWIDTH-1:0]          din,
  input  logic [DWIDTH/8-1:0]        be,
  output logic                       rd_valid,
  output logic [DWIDTH-1:0]          dout,
  output logic                       init_busy
);

  localparam int unsigned       DEPTH    = 1 << AWIDTH;
  localparam int unsigned       NBYTES   = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   init_ptr_q, init_ptr_d;
  logic [DWIDTH-1:0]   dout_q, dout_d;
  logic                rd_valid_q, rd_valid_d;

  logic [DWIDTH-1:0]   mem [DEPTH];

  // A single write port is shared by the init sweep and accepted write requests.
  logic [NBYTES-1:0]   mem_we;
  logic [AWIDTH-1:0]   mem_addr;
  logic [DWIDTH-1:0]   mem_wdata;
  logic                accept;

  // Next-state logic: the sweep pointer, the handshake, and the write-port and read-register controls.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    mem_we     = '0;
    mem_addr   = addr;
    mem_wdata  = din;
    req_ready  = (state_q == ST_READY) && !init_start;
    accept     = req_valid && req_ready;

    case (state_q)
      ST_INIT: begin
        mem_we    = '1;
        mem_addr  = init_ptr_q;
        mem_wdata = INIT_VALUE;
        if (init_ptr_q == LAST_PTR) begin
          init_ptr_d = '0;
          state_d    = ST_READY;
        end else begin
          init_ptr_d = init_ptr_q + AWIDTH'(1);
        end
      end
      ST_READY: begin
        if (init_start) begin
          state_d = ST_INIT;
        end else if (accept) begin
          if (we) begin
            mem_we = be;
          end else begin
            rd_valid_d = 1'b1;
            dout_d     = mem[addr];
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control and read-data registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Array write with byte-lane enables. The array has no reset; the sweep clears it.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (mem_we[i]) begin
        mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign dout      = dout_q;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_ram_sync_read_be_init.sv
// Directed scoreboard bench for ram_sync_read_be_init.
// Read issues push the expected data and cycle number; a monitor pops them on rd_valid.
module tb_ram_sync_read_be_init;

  localparam logic [31:0] INIT = 32'h5A5A_C3C3;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_start;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic        rd_valid;
  logic [31:0] dout;
  logic        init_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          cyc_q[$];

  ram_sync_read_be_init #(
    .AWIDTH(3),
    .DWIDTH(32),
    .INIT_VALUE(INIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .init_start(init_start),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .we(we),
    .addr(addr),
    .din(din),
    .be(be),
    .rd_valid(rd_valid),
    .dout(dout),
    .init_busy(init_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One request cycle: drive at posedge+1, check req_ready, and let the next edge accept it.
  task automatic issue(input bit w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit exp_acc, input logic [31:0] exp_rd);
    req_valid = 1'b1;
    we        = w;
    addr      = a;
    din       = d;
    be        = b;
    #1;
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_acc});
    @(posedge clock);
    #1;
    if (exp_acc && !w) begin
      exp_q.push_back(exp_rd);
      cyc_q.push_back(cyc);
    end
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    issue(1'b1, a, d, b, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp_rd);
    issue(1'b0, a, 32'h0, 4'h0, 1'b1, exp_rd);
  endtask

  // Counts edges until init_busy drops; req_ready must stay low meanwhile.
  task automatic wait_sweep(input string name);
    int n  = 0;
    bit ok = 1'b1;
    while (init_busy && n < 20) begin
      if (req_ready) ok = 1'b0;
      @(posedge clock);
      #1;
      n++;
    end
    req_valid = 1'b0;
    chk({name, "_len"}, n, 8);
    chk({name, "_ready_low"}, {31'b0, ok}, 32'd1);
    chk({name, "_ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding read.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rd_valid actual=%h required=none", dout);
        end else begin
          chk("rd_data", dout, exp_q.pop_front());
          chk("rd_latency_cycle", cyc, cyc_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    init_start = 1'b0;
    // Write request held throughout reset and the sweep; it must never land.
    req_valid  = 1'b1;
    we         = 1'b1;
    addr       = 3'd2;
    din        = 32'hDEAD_BEEF;
    be         = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_init_busy", {31'b0, init_busy}, 32'd1);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_dout", dout, 32'h0);
    reset = 1'b0;
    wait_sweep("sweep1");

    for (int a = 0; a < 8; a++) rd(3'(a), INIT);
    drain("drain_init_reads");

    // Full-word write, partial write on lanes 0 and 2, then a back-to-back read.
    wr(3'd3, 32'hAABB_CCDD, 4'b1111);
    wr(3'd3, 32'h1122_3344, 4'b0101);
    rd(3'd3, 32'hAA22_CC44);
    drain("drain_merge");

    wr(3'd5, 32'h1234_5678, 4'b0000);
    rd(3'd5, INIT);
    for (int a = 0; a < 8; a++) rd(3'(a), (a == 3) ? 32'hAA22_CC44 : INIT);
    drain("drain_seq");

    wr(3'd2, 32'hCAFE_F00D, 4'hF);
    rd(3'd2, 32'hCAFE_F00D);
    drain("drain_raw");

    // Re-init request blocks a concurrent read and leaves dout alone.
    init_start = 1'b1;
    issue(1'b0, 3'd7, 32'h0, 4'h0, 1'b0, 32'h0);
    init_start = 1'b0;
    chk("reinit_busy", {31'b0, init_busy}, 32'd1);
    wait_sweep("sweep2");
    chk("dout_hold", dout, 32'hCAFE_F00D);
    for (int a = 0; a < 8; a++) rd(3'(a), INIT);
    drain("drain_reinit");

    // Reset three edges into a sweep.
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_sweep_busy", {31'b0, init_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_sweep_rst_dout", dout, 32'h0);
    chk("mid_sweep_rst_busy", {31'b0, init_busy}, 32'd1);
    #2 reset = 1'b0;
    wait_sweep("sweep3");

    // Reset one cycle after a read accept discards the result.
    wr(3'd0, 32'h0BAD_F00D, 4'hF);
    rd(3'd0, 32'h0BAD_F00D);
    chk("pre_rst_rd_valid", {31'b0, rd_valid}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    #1;
    chk("rst_flush_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_flush_dout", dout, 32'h0);
    #2 reset = 1'b0;
    wait_sweep("sweep4");
    for (int a = 0; a < 8; a++) rd(3'(a), INIT);
    drain("drain_final");

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
